// File: rtl/vga_raster_timing_if.sv
// Raster timing bundle: pixel column, split line number, syncs and blank.
// The timing generator drives it as master; pixel fetch and interrupt logic listen as slave.
interface vga_raster_timing_if;
   logic [10:0] x;
   logic [4:0]  y_hi;
   logic [5:0]  y_lo;
   logic        hsync;
   logic        vsync;
   logic        blank;

   modport master (output x, y_hi, y_lo, hsync, vsync, blank);
   modport slave  (input  x, y_hi, y_lo, hsync, vsync, blank);
endinterface

// File: rtl/vga_raster_timing.sv
// VGA raster timing generator (default 1024x768@60, one pixel per clock).
// All outputs are registered; syncs and blank are decoded from the next counter values.
module vga_raster_timing #(
   parameter int H_ACTIVE = 1024,
   parameter int H_FP     = 24,
   parameter int H_SYNC   = 136,
   parameter int H_BP     = 160,
   parameter int V_ACTIVE = 768,
   parameter int V_FP     = 3,
   parameter int V_SYNC   = 6,
   parameter int V_BP     = 29,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   vga_raster_timing_if.master vga
);

   localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [10:0] r_x;
   logic [4:0]  r_yHi;
   logic [5:0]  r_yLo;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_blank;

   logic [10:0] w_xNext;
   logic [4:0]  w_yHiNext;
   logic [5:0]  w_yLoNext;
   logic [10:0] w_lineNext;
   logic        w_hsyncNext;
   logic        w_vsyncNext;
   logic        w_blankNext;

   // The line number lives only as {y_hi, y_lo}; y_lo carries into y_hi at 63.
   always_comb begin
      w_xNext   = r_x + 11'd1;
      w_yHiNext = r_yHi;
      w_yLoNext = r_yLo;
      if (r_x == H_LAST) begin
         w_xNext = '0;
         if ({r_yHi, r_yLo} == V_LAST) begin
            w_yHiNext = '0;
            w_yLoNext = '0;
         end else if (r_yLo == 6'd63) begin
            w_yLoNext = '0;
            w_yHiNext = r_yHi + 5'd1;
         end else begin
            w_yLoNext = r_yLo + 6'd1;
         end
      end
   end

   assign w_lineNext  = {w_yHiNext, w_yLoNext};
   assign w_hsyncNext = ((w_xNext >= HS_FIRST) && (w_xNext <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
   assign w_vsyncNext = ((w_lineNext >= VS_FIRST) && (w_lineNext <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
   assign w_blankNext = (w_xNext >= H_VIS) || (w_lineNext >= V_VIS);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_x     <= '0;
         r_yHi   <= '0;
         r_yLo   <= '0;
         r_hsync <= ~SYNC_POL;
         r_vsync <= ~SYNC_POL;
         r_blank <= 1'b0;
      end else begin
         r_x     <= w_xNext;
         r_yHi   <= w_yHiNext;
         r_yLo   <= w_yLoNext;
         r_hsync <= w_hsyncNext;
         r_vsync <= w_vsyncNext;
         r_blank <= w_blankNext;
      end
   end

   assign vga.x     = r_x;
   assign vga.y_hi  = r_yHi;
   assign vga.y_lo  = r_yLo;
   assign vga.hsync = r_hsync;
   assign vga.vsync = r_vsync;
   assign vga.blank = r_blank;

endmodule

// File: tb/tb_vga_raster_timing.sv
// Directed bench: full 1024x768 instance for line timing, plus a shrunken
// active-high-sync instance so whole frames, line carries and frame wraps fit in a short run.
module tb_vga_raster_timing;

   logic clk;
   logic rst;
   int   testsRun;
   int   testsFailed;

   vga_raster_timing_if vgaFull ();
   vga_raster_timing_if vgaSmall ();

   vga_raster_timing dutFull (
      .clk (clk),
      .rst (rst),
      .vga (vgaFull.master)
   );

   // Small mode: line total 26 (hsync x 18..21), frame total 80 lines (vsync lines 73..74).
   vga_raster_timing #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (4),
      .V_ACTIVE (70), .V_FP (3), .V_SYNC (2), .V_BP (5),
      .SYNC_POL (1'b1)
   ) dutSmall (
      .clk (clk),
      .rst (rst),
      .vga (vgaSmall.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic stepClocks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // State vectors below are {x, y_hi, y_lo, hsync, vsync, blank}.
   task automatic test_reset();
      logic [24:0] got;
      doReset();
      got = {vgaFull.x, vgaFull.y_hi, vgaFull.y_lo, vgaFull.hsync, vgaFull.vsync, vgaFull.blank};
      testsRun++;
      if (got !== {11'd0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL reset_full got %h expected %h", got, {11'd0, 5'd0, 6'd0, 3'b110});
      end
      got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
      testsRun++;
      if (got !== {11'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL reset_small got %h expected %h", got, {11'd0, 5'd0, 6'd0, 3'b000});
      end
      stepClocks(1);
      got = {vgaFull.x, vgaFull.y_hi, vgaFull.y_lo, vgaFull.hsync, vgaFull.vsync, vgaFull.blank};
      testsRun++;
      if (got !== {11'd1, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL release_x1 got %h expected %h", got, {11'd1, 5'd0, 6'd0, 3'b110});
      end
      stepClocks(1);
      testsRun++;
      if (vgaFull.x !== 11'd2) begin
         testsFailed++;
         $display("[TB] FAIL release_x2 got %0d expected 2", vgaFull.x);
      end
   endtask

   task automatic test_hsync();
      logic [24:0] got;
      logic [24:0] exp [0:6];
      int          steps [0:6];
      steps = '{1023, 1, 23, 1, 135, 1, 159};
      exp[0] = {11'd1023, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0};
      exp[1] = {11'd1024, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1};
      exp[2] = {11'd1047, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1};
      exp[3] = {11'd1048, 5'd0, 6'd0, 1'b0, 1'b1, 1'b1};
      exp[4] = {11'd1183, 5'd0, 6'd0, 1'b0, 1'b1, 1'b1};
      exp[5] = {11'd1184, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1};
      exp[6] = {11'd1343, 5'd0, 6'd0, 1'b1, 1'b1, 1'b1};
      doReset();
      for (int k = 0; k < 7; k++) begin
         stepClocks(steps[k]);
         got = {vgaFull.x, vgaFull.y_hi, vgaFull.y_lo, vgaFull.hsync, vgaFull.vsync, vgaFull.blank};
         testsRun++;
         if (got !== exp[k]) begin
            testsFailed++;
            $display("[TB] FAIL hsync_step%0d got %h expected %h", k, got, exp[k]);
         end
      end
      stepClocks(1);
      got = {vgaFull.x, vgaFull.y_hi, vgaFull.y_lo, vgaFull.hsync, vgaFull.vsync, vgaFull.blank};
      testsRun++;
      if (got !== {11'd0, 5'd0, 6'd1, 1'b1, 1'b1, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL line1_start got %h expected %h", got, {11'd0, 5'd0, 6'd1, 3'b110});
      end
   endtask

   task automatic test_hsyncWidth();
      int          lowCount;
      logic [24:0] got;
      lowCount = 0;
      for (int i = 0; i < 1344; i++) begin
         if (vgaFull.hsync === 1'b0) lowCount++;
         stepClocks(1);
      end
      testsRun++;
      if (lowCount != 136) begin
         testsFailed++;
         $display("[TB] FAIL hsync_low_clocks got %0d expected 136", lowCount);
      end
      got = {vgaFull.x, vgaFull.y_hi, vgaFull.y_lo, vgaFull.hsync, vgaFull.vsync, vgaFull.blank};
      testsRun++;
      if (got !== {11'd0, 5'd0, 6'd2, 1'b1, 1'b1, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL line2_start got %h expected %h", got, {11'd0, 5'd0, 6'd2, 3'b110});
      end
   endtask

   task automatic test_midLineReset();
      logic [24:0] got;
      stepClocks(500);
      got = {vgaFull.x, vgaFull.y_hi, vgaFull.y_lo, vgaFull.hsync, vgaFull.vsync, vgaFull.blank};
      testsRun++;
      if (got !== {11'd500, 5'd0, 6'd2, 1'b1, 1'b1, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL pre_reset_x500 got %h expected %h", got, {11'd500, 5'd0, 6'd2, 3'b110});
      end
      rst = 1'b1;
      stepClocks(1);
      rst = 1'b0;
      got = {vgaFull.x, vgaFull.y_hi, vgaFull.y_lo, vgaFull.hsync, vgaFull.vsync, vgaFull.blank};
      testsRun++;
      if (got !== {11'd0, 5'd0, 6'd0, 1'b1, 1'b1, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL mid_line_reset got %h expected %h", got, {11'd0, 5'd0, 6'd0, 3'b110});
      end
      stepClocks(1);
      testsRun++;
      if (vgaFull.x !== 11'd1) begin
         testsFailed++;
         $display("[TB] FAIL post_reset_count got %0d expected 1", vgaFull.x);
      end
   endtask

   task automatic test_lineCarry();
      logic [24:0] got;
      doReset();
      stepClocks(64 * 26 - 1);
      got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
      testsRun++;
      if (got !== {11'd25, 5'd0, 6'd63, 1'b0, 1'b0, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL line63_end got %h expected %h", got, {11'd25, 5'd0, 6'd63, 3'b001});
      end
      stepClocks(1);
      got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
      testsRun++;
      if (got !== {11'd0, 5'd1, 6'd0, 1'b0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL line64_carry got %h expected %h", got, {11'd0, 5'd1, 6'd0, 3'b000});
      end
   endtask

   task automatic test_frameWrap();
      logic [24:0] got;
      doReset();
      stepClocks(80 * 26 - 1);
      got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
      testsRun++;
      if (got !== {11'd25, 5'd1, 6'd15, 1'b0, 1'b0, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL frame_last got %h expected %h", got, {11'd25, 5'd1, 6'd15, 3'b001});
      end
      stepClocks(1);
      got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
      testsRun++;
      if (got !== {11'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL frame_wrap got %h expected %h", got, {11'd0, 5'd0, 6'd0, 3'b000});
      end
   endtask

   task automatic test_frameWalk();
      int          mismatches;
      int          firstBad;
      int          vsHigh;
      int          blankCount;
      int          ex;
      int          ln;
      logic        eHs;
      logic        eVs;
      logic        eBl;
      logic [24:0] got;
      logic [24:0] exp;
      mismatches = 0;
      firstBad   = -1;
      vsHigh     = 0;
      blankCount = 0;
      doReset();
      for (int c = 0; c < 2080; c++) begin
         ex  = c % 26;
         ln  = c / 26;
         eHs = (ex >= 18) && (ex <= 21);
         eVs = (ln >= 73) && (ln <= 74);
         eBl = (ex >= 16) || (ln >= 70);
         exp = {11'(ex), 5'(ln / 64), 6'(ln % 64), eHs, eVs, eBl};
         got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
         if (got !== exp) begin
            mismatches++;
            if (firstBad < 0) firstBad = c;
         end
         if (vgaSmall.vsync === 1'b1) vsHigh++;
         if (vgaSmall.blank === 1'b1) blankCount++;
         stepClocks(1);
      end
      testsRun++;
      if (mismatches != 0) begin
         testsFailed++;
         $display("[TB] FAIL frame_walk mismatched cycles got %0d expected 0 (first at cycle %0d)", mismatches, firstBad);
      end
      testsRun++;
      if (vsHigh != 52) begin
         testsFailed++;
         $display("[TB] FAIL vsync_active_clocks got %0d expected 52", vsHigh);
      end
      testsRun++;
      if (blankCount != 960) begin
         testsFailed++;
         $display("[TB] FAIL blank_clocks got %0d expected 960", blankCount);
      end
      got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
      testsRun++;
      if (got !== {11'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL frame_repeat got %h expected %h", got, {11'd0, 5'd0, 6'd0, 3'b000});
      end
   endtask

   task automatic test_midFrameReset();
      logic [24:0] got;
      doReset();
      stepClocks(73 * 26 + 10);
      got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
      testsRun++;
      if (got !== {11'd10, 5'd1, 6'd9, 1'b0, 1'b1, 1'b1}) begin
         testsFailed++;
         $display("[TB] FAIL in_vsync_state got %h expected %h", got, {11'd10, 5'd1, 6'd9, 3'b011});
      end
      rst = 1'b1;
      stepClocks(1);
      rst = 1'b0;
      got = {vgaSmall.x, vgaSmall.y_hi, vgaSmall.y_lo, vgaSmall.hsync, vgaSmall.vsync, vgaSmall.blank};
      testsRun++;
      if (got !== {11'd0, 5'd0, 6'd0, 1'b0, 1'b0, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL mid_frame_reset got %h expected %h", got, {11'd0, 5'd0, 6'd0, 3'b000});
      end
   endtask

   initial begin
      rst         = 1'b1;
      testsRun    = 0;
      testsFailed = 0;
      test_reset();
      test_hsync();
      test_hsyncWidth();
      test_midLineReset();
      test_lineCarry();
      test_frameWrap();
      test_frameWalk();
      test_midFrameReset();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
